m_dmem_bridge: RTL and testbench
================================

# m_dmem_bridge

Memory-stage data-bus bridge that sits directly downstream of the M-stage byte-enable/data-extension logic. It takes the word address, byte enables, shifted write data and load request produced there, and drives a variable-latency word-wide data bus with a request/grant/rvalid handshake. It returns raw read words on `m_data_rdata` for load extension. Stores are posted through a single-entry write buffer; the block raises `stall` to freeze the pipeline while a load is outstanding or the buffer is occupied.

## Interface
- `ADDR_W`, 32, byte-address width; bus address is word-aligned.
- `clk`  in  1  pipeline clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `m_data_addr`  in  ADDR_W  byte address of M-stage access.
- `m_data_byteen`  in  4  store byte enables; nonzero means store.
- `m_data_wdata`  in  32  store data, already lane-shifted.
- `m_data_rd`  in  1  M-stage instruction is a load.
- `m_data_rdata`  out  32  raw word from last completed load.
- `stall`  out  1  freeze F/D/E/M this cycle.
- `bus_req`  out  1  bus request valid.
- `bus_we`  out  1  1 = write, 0 = read.
- `bus_addr`  out  ADDR_W  `{addr[ADDR_W-1:2], 2'b00}`.
- `bus_byteen`  out  4  write byte enables; 0 on reads.
- `bus_wdata`  out  32  write data.
- `bus_gnt`  in  1  bus accepts request this cycle.
- `bus_rvalid`  in  1  read data valid.
- `bus_rdata`  in  32  read data.

## Operation
- Write buffer: `wb_valid`, `wb_addr`, `wb_be`, `wb_data`.
- Store (`m_data_byteen != 0`) in IDLE:
  - Accepted into the buffer if it is empty, or if it is draining this cycle (`bus_req & bus_we & bus_gnt`).
  - `stall`=0 on the accept cycle; otherwise `stall`=1 until accepted.
- If `m_data_byteen != 0` and `m_data_rd`=1 together, the store wins and the load is ignored.
- Load FSM states: IDLE, RD_REQ, RD_WAIT, RD_DONE.
  - IDLE: `m_data_rd`=1 and `wb_valid`=0 → latch address, go RD_REQ, `stall`=1. With `wb_valid`=1, stay IDLE with `stall`=1; loads never bypass a buffered store.
  - RD_REQ: `bus_req`=1, `bus_we`=0, latched address, `stall`=1. `bus_gnt` → RD_WAIT.
  - RD_WAIT: `stall`=1. `bus_rvalid` → capture `bus_rdata` into `m_data_rdata`, go RD_DONE.
  - RD_DONE: `stall`=0 (pipeline advances), → IDLE.
- Bus muxing:
  - `bus_req` = `wb_valid` | (state==RD_REQ).
  - `bus_we` = `wb_valid`; write fields come from the buffer when `wb_valid`.
  - Read and write are never requested together: reads start only with the buffer empty, and stores are not accepted outside IDLE.
- `m_data_rdata` holds its value until the next load completes.
- No access (byteen 0, rd 0): `stall`=0; the buffer keeps draining.

## Timing
- Reset values: `stall`=0, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_byteen`=0, `bus_wdata`=0, `m_data_rdata`=0, FSM=IDLE, `wb_valid`=0.
- Reset mid-operation: a buffered store is discarded and any in-flight read is abandoned. A `bus_rvalid` arriving after reset is ignored.
- Store into empty buffer: 0 stall cycles; `bus_req` rises the next cycle.
- Load, empty buffer, `bus_gnt` in RD_REQ, `bus_rvalid` one cycle later: 3 stall cycles, data visible in cycle 3 (RD_DONE).
- `bus_rvalid` never coincides with `bus_gnt` of the same read; an rvalid in RD_REQ or IDLE is ignored.
- Each extra cycle of grant or rvalid delay adds one stall cycle.
- Bus outputs are combinational from registered state only; there are no combinational paths from `bus_*` inputs to bus outputs.

## Test plan
- Reset: hold `reset`=0 with random inputs → every output at its reset value; release → `stall`=0, `bus_req`=0.
- Store `addr`=0x100, `be`=1111, `wdata`=0x12345678, `bus_gnt`=1 → `stall`=0 on the accept cycle; next cycle `bus_req`=1, `bus_we`=1, `bus_addr`=0x100; buffer empty after.
- Back-to-back stores to 0x100 (be 0011) and 0x104 (be 1000), `bus_gnt` low 3 cycles → second store stalls 3 cycles and is accepted on the grant cycle; the bus then sees 0x104 with be 1000.
- Store 0x200 = 0xCAFEF00D then load 0x200, memory model rvalid one cycle after grant → load stalls until the write is granted, then 3 more stall cycles; `m_data_rdata`=0xCAFEF00D.
- Load 0x300 with rvalid delayed 5 cycles after grant → `stall` held throughout, `m_data_rdata` updates only in RD_DONE and is held through later non-load cycles.
- Drop `reset` in RD_WAIT, then pulse `bus_rvalid` → `bus_req`=0 and `stall`=0 immediately; `m_data_rdata` stays 0.

Source files
------------

// File: rtl/m_dmem_bridge.sv
// M-stage data-bus bridge: posts stores through a one-entry write buffer and
// runs blocking loads over a request/grant/rvalid word bus.
module m_dmem_bridge #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m_data_addr,
  input  logic [3:0]        m_data_byteen,
  input  logic [31:0]       m_data_wdata,
  input  logic              m_data_rd,
  output logic [31:0]       m_data_rdata,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_byteen,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    RD_DONE = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic                wb_valid_r;
  logic [ADDR_W-1:0]   wb_addr_r;
  logic [3:0]          wb_be_r;
  logic [31:0]         wb_data_r;
  logic [ADDR_W-1:0]   rd_addr_r;
  logic [31:0]         rdata_r;

  logic [ADDR_W-1:0]   word_addr_s;
  logic                is_store_s;
  logic                drain_s;
  logic                wb_accept_s;
  logic                rd_start_s;
  logic                rd_capture_s;
  logic                stall_s;
  logic                addr_lo_unused_s;

  assign word_addr_s      = {m_data_addr[ADDR_W-1:2], 2'b00};
  assign addr_lo_unused_s = ^m_data_addr[1:0];
  assign is_store_s       = (m_data_byteen != 4'b0000);
  // A buffered write is always the one on the bus, so a grant with wb_valid drains it.
  assign drain_s          = wb_valid_r & bus_gnt;

  // Next-state, store acceptance and stall decode
  always_comb begin
    state_nxt_s  = state_r;
    wb_accept_s  = 1'b0;
    rd_start_s   = 1'b0;
    rd_capture_s = 1'b0;
    stall_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (is_store_s) begin
          wb_accept_s = ~wb_valid_r | drain_s;
          stall_s     = wb_valid_r & ~drain_s;
        end else if (m_data_rd) begin
          stall_s = 1'b1;
          if (!wb_valid_r) begin
            rd_start_s  = 1'b1;
            state_nxt_s = RD_REQ;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          stall_s = 1'b0;
        end
      end
      RD_REQ: begin
        stall_s = 1'b1;
        if (bus_gnt) begin
          state_nxt_s = RD_WAIT;
        end else begin
          state_nxt_s = RD_REQ;
        end
      end
      RD_WAIT: begin
        stall_s = 1'b1;
        if (bus_rvalid) begin
          rd_capture_s = 1'b1;
          state_nxt_s  = RD_DONE;
        end else begin
          state_nxt_s = RD_WAIT;
        end
      end
      RD_DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Load FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Single-entry write buffer; a new store may replace an entry draining this cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid_r <= 1'b0;
      wb_addr_r  <= '0;
      wb_be_r    <= 4'b0000;
      wb_data_r  <= 32'h0000_0000;
    end else if (wb_accept_s) begin
      wb_valid_r <= 1'b1;
      wb_addr_r  <= word_addr_s;
      wb_be_r    <= m_data_byteen;
      wb_data_r  <= m_data_wdata;
    end else if (drain_s) begin
      wb_valid_r <= 1'b0;
    end
  end

  // Read address latch and returned-word holding register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr_r <= '0;
      rdata_r   <= 32'h0000_0000;
    end else begin
      if (rd_start_s) begin
        rd_addr_r <= word_addr_s;
      end
      if (rd_capture_s) begin
        rdata_r <= bus_rdata;
      end
    end
  end

  // Bus drive from registered state only; write and read never overlap
  always_comb begin
    bus_req = wb_valid_r | (state_r == RD_REQ);
    bus_we  = wb_valid_r;
    if (wb_valid_r) begin
      bus_addr   = wb_addr_r;
      bus_byteen = wb_be_r;
      bus_wdata  = wb_data_r;
    end else begin
      bus_addr   = rd_addr_r;
      bus_byteen = 4'b0000;
      bus_wdata  = 32'h0000_0000;
    end
  end

  // Stall is forced low while reset is held so the pipeline is released immediately.
  assign stall        = stall_s & reset;
  assign m_data_rdata = rdata_r;

endmodule

// File: tb/tb_m_dmem_bridge.sv
// Scoreboard bench for m_dmem_bridge: a memory-level reference model predicts
// bus writes and load data; a monitor compares them as the DUT presents them.
module tb_m_dmem_bridge;

  logic        clk;
  logic        reset;
  logic [31:0] m_data_addr;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_wdata;
  logic        m_data_rd;
  logic [31:0] m_data_rdata;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  m_dmem_bridge #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .m_data_addr(m_data_addr), .m_data_byteen(m_data_byteen),
    .m_data_wdata(m_data_wdata), .m_data_rd(m_data_rd),
    .m_data_rdata(m_data_rdata), .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_byteen(bus_byteen), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] bus_mem [logic [31:0]];

  int n_checks = 0;
  int n_errors = 0;

  int gnt_pct   = 100;
  int gnt_block = 0;
  int rv_extra  = 0;
  bit bus_rand  = 1'b1;
  bit force_rv  = 1'b0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                        input logic [31:0] data);
    logic [31:0] w;
    w = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) w[8*i +: 8] = data[8*i +: 8];
    end
    return w;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] bus_read(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus slave: samples handshakes on negedge, drives gnt/rvalid just after posedge.
  initial begin
    bit          rd_pend;
    logic [31:0] rd_a;
    int          rd_cnt;
    rd_pend = 1'b0; rd_a = 32'h0; rd_cnt = 0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        rd_pend = 1'b0;
      end else if (bus_req && bus_gnt) begin
        if (bus_we) begin
          bus_mem[bus_addr] = merge(bus_read(bus_addr), bus_byteen, bus_wdata);
        end else begin
          rd_pend = 1'b1;
          rd_a    = bus_addr;
          rd_cnt  = (rv_extra < 0) ? int'($urandom_range(0, 3)) : rv_extra;
        end
      end
      @(posedge clk); #1;
      bus_rvalid = 1'b0;
      if (bus_rand) begin
        bus_gnt    = 1'($urandom_range(0, 1));
        bus_rvalid = 1'($urandom_range(0, 1));
        bus_rdata  = $urandom;
      end else begin
        if (force_rv) begin
          bus_rvalid = 1'b1;
          bus_rdata  = 32'hDEAD_BEEF;
        end else if (rd_pend) begin
          if (rd_cnt == 0) begin
            bus_rvalid = 1'b1;
            bus_rdata  = bus_read(rd_a);
            rd_pend    = 1'b0;
          end else begin
            rd_cnt--;
          end
        end
        if (!bus_req) begin
          bus_gnt = 1'b0;
        end else if (gnt_block > 0) begin
          bus_gnt = 1'b0;
          gnt_block--;
        end else begin
          bus_gnt = ($urandom_range(1, 100) <= gnt_pct);
        end
      end
    end
  end

  // Monitor: pops expectations when the DUT writes on the bus or retires a load.
  initial begin
    wr_t         e;
    logic [31:0] ed;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bus_req && bus_we && bus_gnt) begin
          if (exp_wr.size() == 0) begin
            chk("wr_unexpected", 64'd1, 64'd0);
          end else begin
            e = exp_wr.pop_front();
            chk("wr_addr", bus_addr, e.addr);
            chk("wr_be", bus_byteen, e.be);
            chk("wr_data", bus_wdata, e.data);
          end
        end
        if (bus_req && !bus_we) chk("rd_byteen", bus_byteen, 4'b0000);
        if (m_data_rd && m_data_byteen == 4'b0000 && !stall) begin
          if (exp_rd.size() == 0) begin
            chk("ld_unexpected", 64'd1, 64'd0);
          end else begin
            ed = exp_rd.pop_front();
            chk("ld_data", m_data_rdata, ed);
          end
        end
      end
    end
  end

  task automatic nop_cycle();
    @(posedge clk); #1;
    m_data_rd = 1'b0; m_data_addr = 32'h0; m_data_byteen = 4'b0000; m_data_wdata = 32'h0;
    @(negedge clk);
  endtask

  // Present one M-stage access, record its expectation, hold it until stall drops.
  task automatic do_op(input logic rd, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] data, output int stalls, output bit changed);
    logic [31:0] wa;
    logic [31:0] r0;
    int          budget;
    stalls = 0; changed = 1'b0; budget = 0;
    wa = {addr[31:2], 2'b00};
    @(posedge clk); #1;
    m_data_rd = rd; m_data_addr = addr; m_data_byteen = be; m_data_wdata = data;
    if (be != 4'b0000) begin
      exp_wr.push_back('{addr: wa, be: be, data: data});
      ref_mem[wa] = merge(ref_read(wa), be, data);
    end else if (rd) begin
      exp_rd.push_back(ref_read(wa));
    end
    r0 = m_data_rdata;
    @(negedge clk);
    while (stall && budget < 200) begin
      stalls++; budget++;
      if (m_data_rdata !== r0) changed = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk("op_complete", stall, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          st;
    bit          ch;
    int          k;
    logic [31:0] a;
    reset = 1'b0;
    m_data_rd = 1'b0; m_data_addr = 32'h0; m_data_byteen = 4'b0000; m_data_wdata = 32'h0;

    // Reset held with random pipeline and bus inputs.
    repeat (6) begin
      @(posedge clk); #1;
      m_data_addr = $urandom; m_data_byteen = 4'($urandom_range(0, 15));
      m_data_wdata = $urandom; m_data_rd = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_stall", stall, 1'b0);
      chk("rst_bus_req", bus_req, 1'b0);
      chk("rst_bus_we", bus_we, 1'b0);
      chk("rst_bus_addr", bus_addr, 32'h0);
      chk("rst_bus_byteen", bus_byteen, 4'b0000);
      chk("rst_bus_wdata", bus_wdata, 32'h0);
      chk("rst_rdata", m_data_rdata, 32'h0);
    end
    m_data_rd = 1'b0; m_data_addr = 32'h0; m_data_byteen = 4'b0000; m_data_wdata = 32'h0;
    reset = 1'b1; bus_rand = 1'b0;
    @(negedge clk);
    chk("rel_stall", stall, 1'b0);
    chk("rel_bus_req", bus_req, 1'b0);

    // Single store into empty buffer.
    gnt_pct = 100; rv_extra = 0;
    do_op(1'b0, 32'h100, 4'b1111, 32'h1234_5678, st, ch);
    chk("st_accept_stall", st, 0);
    nop_cycle();
    chk("st_bus_req", bus_req, 1'b1);
    chk("st_bus_we", bus_we, 1'b1);
    chk("st_bus_addr", bus_addr, 32'h100);
    nop_cycle();
    chk("st_wb_empty", bus_req, 1'b0);

    // Back-to-back stores with the grant held off three cycles.
    gnt_block = 3;
    do_op(1'b0, 32'h100, 4'b0011, $urandom, st, ch);
    chk("b2b_first_stall", st, 0);
    do_op(1'b0, 32'h104, 4'b1000, $urandom, st, ch);
    chk("b2b_second_stall", st, 3);
    nop_cycle();
    chk("b2b_bus_addr", bus_addr, 32'h104);
    chk("b2b_bus_be", bus_byteen, 4'b1000);
    nop_cycle();

    // Store then load of the same word: load waits for the write grant.
    gnt_block = 2;
    do_op(1'b0, 32'h200, 4'b1111, 32'hCAFE_F00D, st, ch);
    chk("sl_store_stall", st, 0);
    do_op(1'b1, 32'h200, 4'b0000, 32'h0, st, ch);
    chk("sl_load_stall", st, 6);
    chk("sl_rdata", m_data_rdata, 32'hCAFE_F00D);

    // Slow read: rvalid five cycles after grant.
    rv_extra = 4;
    do_op(1'b1, 32'h300, 4'b0000, 32'h0, st, ch);
    chk("slow_ld_stall", st, 7);
    chk("slow_ld_rdata_early", ch, 1'b0);
    repeat (3) nop_cycle();
    chk("slow_ld_rdata_held", m_data_rdata, ref_read(32'h300));

    // Reset during RD_WAIT, then a stray rvalid.
    rv_extra = 10;
    @(posedge clk); #1;
    m_data_rd = 1'b1; m_data_addr = 32'h340; m_data_byteen = 4'b0000;
    repeat (2) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rw_wait_stall", stall, 1'b1);
    #2;
    reset = 1'b0; m_data_rd = 1'b0; m_data_addr = 32'h0;
    #1;
    chk("rw_rst_bus_req", bus_req, 1'b0);
    chk("rw_rst_stall", stall, 1'b0);
    chk("rw_rst_rdata", m_data_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1; force_rv = 1'b1;
    @(negedge clk);
    force_rv = 1'b0;
    chk("rw_after_stall", stall, 1'b0);
    chk("rw_after_bus_req", bus_req, 1'b0);
    @(negedge clk);
    chk("rw_stray_rvalid_rdata", m_data_rdata, 32'h0);

    // Randomized mix of stores, loads, store+load collisions and idle cycles.
    rv_extra = -1; gnt_pct = 60;
    for (int i = 0; i < 300; i++) begin
      k = int'($urandom_range(0, 9));
      a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if (k < 4) begin
        do_op(k == 0, a, 4'($urandom_range(1, 15)), $urandom, st, ch);
      end else if (k < 7) begin
        do_op(1'b1, a, 4'b0000, $urandom, st, ch);
      end else begin
        do_op(1'b0, a, 4'b0000, $urandom, st, ch);
        chk("idle_stall", st, 0);
      end
    end

    gnt_pct = 100;
    repeat (6) nop_cycle();
    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("ld_queue_drained", exp_rd.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
